fpdiv_ctrl: RTL and testbench
=============================

FPDIV_CTRL -- requirements
Module: fpdiv_ctrl

Interface
REQ-001 The parameter list SHALL be: DIV_ITERS, 4, Goldschmidt iterations for divide (legal 1..15).
REQ-002 The parameter list SHALL be: SQRT_ITERS, 5, Goldschmidt iterations for square root (legal 1..15).
REQ-003 The module SHALL have the ports:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request a new operation.
- op_type  in  1  0 = divide, 1 = square root; sampled with start.
- flush  in  1  abort any operation in progress.
- Ztype  in  3  result class from the exception classifier: 000 normal, 001 QNaN, 010 Inf, 011 zero, 110 divide-by-zero.
- Invalid  in  1  invalid-operation indication from the classifier.
- Denorm  in  1  denormal-operand indication from the classifier.
- busy  out  1  operation in progress.
- load_op  out  1  load the operand registers.
- norm_en  out  1  normalize the denormal operand this cycle.
- iter_en  out  1  perform a Goldschmidt step this cycle.
- iter_cnt  out  4  index of the current iteration.
- first_iter  out  1  the current iteration is iteration 0 (select seed/reciprocal estimate).
- round_en  out  1  round and pack this cycle.
- bypass  out  1  the result is special (Ztype != 000); mux in the special constant.
- done  out  1  result valid, single-cycle pulse.
- flag_nv  out  1  invalid-operation flag for the last completed operation.
- flag_dz  out  1  divide-by-zero flag for the last completed operation.

Function
REQ-004 The FSM SHALL have the states IDLE, CLASS, NORM, ITER, ROUND and DONE, with state held in registers.
REQ-005 load_op SHALL equal start & (state==IDLE) & ~flush (Mealy); the same condition moves the FSM to CLASS and latches op_type into op_r.
REQ-006 start SHALL be ignored in every state except IDLE; no queuing and no error indication.
REQ-007 busy SHALL be 1 in every state other than IDLE.
REQ-008 In CLASS the block SHALL sample Ztype, Invalid and Denorm into byp_r, nv_r, dz_r (Ztype==110) and den_r.
REQ-009 The next state out of CLASS SHALL be:
- DONE if Ztype != 000.
- NORM if Denorm is 1.
- ITER otherwise.
REQ-010 NORM SHALL last exactly one cycle with norm_en=1, then go to ITER.
REQ-011 On entry to ITER, iter_cnt SHALL be 0.
REQ-012 While in ITER: iter_en=1, first_iter=(iter_cnt==0), and iter_cnt increments by 1 each cycle.
REQ-013 The FSM SHALL leave ITER for ROUND in the cycle where iter_cnt == N-1, with N=DIV_ITERS if op_r=0 and N=SQRT_ITERS if op_r=1.
REQ-014 ROUND SHALL last one cycle with round_en=1, then go to DONE.
REQ-015 DONE SHALL last one cycle with done=1, then go to IDLE; bypass SHALL equal byp_r while in DONE and be 0 otherwise.
REQ-016 flag_nv and flag_dz SHALL update from nv_r/dz_r on the cycle done asserts and hold until the next done.
REQ-017 Latency from the start-acceptance edge to done SHALL be:
- normal operand: N+3 cycles.
- denormal operand: N+4 cycles.
- special result: 2 cycles.
REQ-018 flush=1 in any state SHALL force the next state to IDLE and clear iter_cnt.
REQ-019 A flushed operation SHALL produce no done pulse and leave flag_nv/flag_dz unchanged.
REQ-020 If flush and start are both 1 in IDLE, flush SHALL win: load_op=0 and the FSM stays in IDLE.
REQ-021 iter_cnt SHALL never wrap: it is 0 outside ITER and at most 14 inside ITER.
REQ-022 A start in the DONE cycle SHALL be ignored; back-to-back operations need start asserted in IDLE.
REQ-023 All outputs other than load_op SHALL be Moore-decoded from state and registers.

Reset
REQ-024 While reset_n=0 the block SHALL asynchronously hold state=IDLE, iter_cnt=0, and op_r, byp_r, nv_r, dz_r, den_r, flag_nv and flag_dz all 0.
REQ-025 While reset_n=0, busy, norm_en, iter_en, first_iter, round_en, bypass and done SHALL all be 0.
REQ-026 load_op SHALL be 0 while reset_n=0 (gated by the reset state).
REQ-027 After reset_n deasserts, the first start SHALL be accepted on the first rising edge.
REQ-028 Reset asserted mid-operation SHALL abort it with no done pulse.

Verification
REQ-029 The bench SHALL cover: divide, Ztype=000, Denorm=0 -> iter_en for 4 cycles with iter_cnt 0,1,2,3; done at cycle 7; flags 0.
REQ-030 The bench SHALL cover: sqrt, Denorm=1 -> one norm_en cycle, then 5 iterations; done at cycle 9.
REQ-031 The bench SHALL cover: divide, Ztype=110 -> done at cycle 2 with bypass=1 and flag_dz=1; iter_en never asserted.
REQ-032 The bench SHALL cover: sqrt, Ztype=001 and Invalid=1 -> done at cycle 2 with bypass=1 and flag_nv=1, flag_dz=0.
REQ-033 The bench SHALL cover: flush at iter_cnt=2 -> IDLE next cycle, no done, flags keep their previous values; a start in ITER is ignored.
REQ-034 The bench SHALL cover: reset_n pulsed low in ROUND -> all outputs 0 immediately; a start right after release -> load_op=1.

Source files
------------

// File: rtl/fpdiv_ctrl.sv
// Goldschmidt divide/sqrt sequencer: CLASS, optional NORM, N ITER steps, ROUND, DONE.
// Latency N+3 (normal), N+4 (denormal), 2 (special); start is ignored while busy.
module fpdiv_ctrl #(
    parameter int DIV_ITERS  = 4,
    parameter int SQRT_ITERS = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       op_type,
    input  logic       flush,
    input  logic [2:0] Ztype,
    input  logic       Invalid,
    input  logic       Denorm,
    output logic       busy,
    output logic       load_op,
    output logic       norm_en,
    output logic       iter_en,
    output logic [3:0] iter_cnt,
    output logic       first_iter,
    output logic       round_en,
    output logic       bypass,
    output logic       done,
    output logic       flag_nv,
    output logic       flag_dz
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLASS = 3'd1,
        NORM  = 3'd2,
        ITER  = 3'd3,
        ROUND = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Iteration counts are legal in 1..15, so the last index always fits in 4 bits.
    localparam logic [3:0] DIV_LAST  = 4'(DIV_ITERS - 1);
    localparam logic [3:0] SQRT_LAST = 4'(SQRT_ITERS - 1);

    state_t     state_q, state_d;
    logic [3:0] iter_cnt_q, iter_cnt_d;
    logic       op_q, op_d;
    logic       byp_q, byp_d;
    logic       nv_q, nv_d;
    logic       dz_q, dz_d;
    logic       den_q, den_d;
    logic       flag_nv_q, flag_nv_d;
    logic       flag_dz_q, flag_dz_d;
    logic [3:0] iter_last;

    assign iter_last = op_q ? SQRT_LAST : DIV_LAST;

    // reset_n gates load_op directly so a held start cannot leak out during reset.
    assign load_op = start & (state_q == IDLE) & ~flush & reset_n;

    always_comb begin
        state_d    = state_q;
        iter_cnt_d = 4'd0;
        op_d       = op_q;
        byp_d      = byp_q;
        nv_d       = nv_q;
        dz_d       = dz_q;
        den_d      = den_q;
        flag_nv_d  = flag_nv_q;
        flag_dz_d  = flag_dz_q;

        case (state_q)
            IDLE: begin
                if (load_op) begin
                    state_d = CLASS;
                    op_d    = op_type;
                end
            end
            CLASS: begin
                byp_d = (Ztype != 3'b000);
                nv_d  = Invalid;
                dz_d  = (Ztype == 3'b110);
                den_d = Denorm;
                if (Ztype != 3'b000) begin
                    state_d = DONE;
                end else if (Denorm) begin
                    state_d = NORM;
                end else begin
                    state_d = ITER;
                end
            end
            NORM: begin
                state_d = ITER;
            end
            ITER: begin
                if (iter_cnt_q == iter_last) begin
                    state_d = ROUND;
                end else begin
                    iter_cnt_d = iter_cnt_q + 4'd1;
                end
            end
            ROUND: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush) begin
            state_d    = IDLE;
            iter_cnt_d = 4'd0;
        end

        // Flags move on the edge entering DONE so they are visible alongside done.
        if (state_d == DONE) begin
            flag_nv_d = nv_d;
            flag_dz_d = dz_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            iter_cnt_q <= 4'd0;
            op_q       <= 1'b0;
            byp_q      <= 1'b0;
            nv_q       <= 1'b0;
            dz_q       <= 1'b0;
            den_q      <= 1'b0;
            flag_nv_q  <= 1'b0;
            flag_dz_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            iter_cnt_q <= iter_cnt_d;
            op_q       <= op_d;
            byp_q      <= byp_d;
            nv_q       <= nv_d;
            dz_q       <= dz_d;
            den_q      <= den_d;
            flag_nv_q  <= flag_nv_d;
            flag_dz_q  <= flag_dz_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign norm_en    = (state_q == NORM) & den_q;
    assign iter_en    = (state_q == ITER);
    assign iter_cnt   = iter_cnt_q;
    assign first_iter = (state_q == ITER) & (iter_cnt_q == 4'd0);
    assign round_en   = (state_q == ROUND);
    assign done       = (state_q == DONE);
    assign bypass     = (state_q == DONE) & byp_q;
    assign flag_nv    = flag_nv_q;
    assign flag_dz    = flag_dz_q;

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Bench for fpdiv_ctrl: directed vector table, random ops against a transaction-level model,
// and hand sequences for flush, start-in-DONE and reset-in-ROUND.
module tb_fpdiv_ctrl;

    localparam int DIV_N  = 4;
    localparam int SQRT_N = 5;

    logic       clk = 1'b0;
    logic       reset_n, start, op_type, flush, Invalid, Denorm;
    logic [2:0] Ztype;
    logic       busy, load_op, norm_en, iter_en, first_iter, round_en, bypass, done, flag_nv, flag_dz;
    logic [3:0] iter_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    bit prev_nv = 1'b0;
    bit prev_dz = 1'b0;

    typedef struct {
        int lat;
        int iters;
        int norm;
        int rnd;
        int byp;
        int nv;
        int dz;
        int proto;
    } res_t;

    typedef struct {
        bit       op;
        bit [2:0] z;
        bit       inv;
        bit       den;
        res_t     exp;
    } vec_t;

    fpdiv_ctrl #(.DIV_ITERS(DIV_N), .SQRT_ITERS(SQRT_N)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op_type(op_type), .flush(flush),
        .Ztype(Ztype), .Invalid(Invalid), .Denorm(Denorm),
        .busy(busy), .load_op(load_op), .norm_en(norm_en), .iter_en(iter_en),
        .iter_cnt(iter_cnt), .first_iter(first_iter), .round_en(round_en),
        .bypass(bypass), .done(done), .flag_nv(flag_nv), .flag_dz(flag_dz)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_res(input string tag, input res_t a, input res_t e);
        check({tag, " latency"}, a.lat, e.lat);
        check({tag, " iterations"}, a.iters, e.iters);
        check({tag, " norm cycles"}, a.norm, e.norm);
        check({tag, " round cycles"}, a.rnd, e.rnd);
        check({tag, " bypass"}, a.byp, e.byp);
        check({tag, " flag_nv"}, a.nv, e.nv);
        check({tag, " flag_dz"}, a.dz, e.dz);
        check({tag, " protocol"}, a.proto, e.proto);
    endtask

    // Expected transaction outcome from the operation's classification alone.
    function automatic res_t model(input bit op, input bit [2:0] z, input bit inv, input bit den);
        res_t r;
        int   n;
        bit   special;
        n       = op ? SQRT_N : DIV_N;
        special = (z != 3'b000);
        r.lat   = special ? 2 : (den ? n + 4 : n + 3);
        r.iters = special ? 0 : n;
        r.norm  = (!special && den) ? 1 : 0;
        r.rnd   = special ? 0 : 1;
        r.byp   = special ? 1 : 0;
        r.nv    = inv ? 1 : 0;
        r.dz    = (z == 3'b110) ? 1 : 0;
        r.proto = 0;
        return r;
    endfunction

    function automatic int outs_vec();
        return int'({busy, norm_en, iter_en, first_iter, round_en, bypass, done,
                     flag_nv, flag_dz, iter_cnt});
    endfunction

    // Called at a negedge; returns at the negedge just after the acceptance edge (cycle 1).
    task automatic issue(input bit op, input bit [2:0] z, input bit inv, input bit den);
        start   = 1'b1;
        op_type = op;
        Ztype   = z;
        Invalid = inv;
        Denorm  = den;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Observes from cycle 1 until done (bounded), then one idle cycle.
    task automatic finish_op(output res_t r);
        int seen;
        r    = '{default: 0};
        seen = 0;
        for (int c = 1; c <= 40; c++) begin
            if (iter_en) begin
                if (iter_cnt != 4'(seen) || first_iter != (seen == 0)) r.proto++;
                seen++;
            end else if (iter_cnt != 4'd0 || first_iter) begin
                r.proto++;
            end
            if (norm_en) r.norm++;
            if (round_en) r.rnd++;
            if (!busy) r.proto++;
            if (bypass && !done) r.proto++;
            if (done) begin
                r.lat = c;
                r.byp = int'(bypass);
                r.nv  = int'(flag_nv);
                r.dz  = int'(flag_dz);
                break;
            end
            @(negedge clk);
        end
        r.iters = seen;
        @(negedge clk);
        if (busy || done || bypass) r.proto++;
        if (int'(flag_nv) != r.nv || int'(flag_dz) != r.dz) r.proto++;
    endtask

    task automatic run_op(input bit op, input bit [2:0] z, input bit inv, input bit den,
                          output res_t r);
        issue(op, z, inv, den);
        finish_op(r);
    endtask

    initial begin
        vec_t     vecs[8];
        res_t     r;
        bit [2:0] zsel[5];
        int       done_cnt;

        zsel = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110};
        vecs[0] = '{0, 3'b000, 0, 0, '{7, 4, 0, 1, 0, 0, 0, 0}};
        vecs[1] = '{1, 3'b000, 0, 1, '{9, 5, 1, 1, 0, 0, 0, 0}};
        vecs[2] = '{0, 3'b110, 0, 0, '{2, 0, 0, 0, 1, 0, 1, 0}};
        vecs[3] = '{1, 3'b001, 1, 0, '{2, 0, 0, 0, 1, 1, 0, 0}};
        vecs[4] = '{0, 3'b000, 0, 1, '{8, 4, 1, 1, 0, 0, 0, 0}};
        vecs[5] = '{1, 3'b000, 0, 0, '{8, 5, 0, 1, 0, 0, 0, 0}};
        vecs[6] = '{0, 3'b010, 0, 1, '{2, 0, 0, 0, 1, 0, 0, 0}};
        vecs[7] = '{1, 3'b011, 1, 0, '{2, 0, 0, 0, 1, 1, 0, 0}};

        reset_n = 1'b0;
        start   = 1'b1;
        op_type = 1'b0;
        flush   = 1'b0;
        Ztype   = 3'b000;
        Invalid = 1'b0;
        Denorm  = 1'b0;

        // Reset holds everything at zero even with start high; release accepts at once.
        @(negedge clk);
        check("reset outputs", outs_vec(), 0);
        check("reset load_op", int'(load_op), 0);
        reset_n = 1'b1;
        #1;
        check("first start load_op", int'(load_op), 1);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("accepted busy", int'(busy), 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush in CLASS busy", int'(busy), 0);
        check("flush in CLASS flags", int'({flag_nv, flag_dz}), 0);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].op, vecs[i].z, vecs[i].inv, vecs[i].den, r);
            check_res($sformatf("vec%0d", i), r, vecs[i].exp);
        end

        for (int i = 0; i < 40; i++) begin
            bit       op, inv, den;
            bit [2:0] z;
            op  = 1'($urandom_range(0, 1));
            inv = 1'($urandom_range(0, 1));
            den = 1'($urandom_range(0, 1));
            z   = zsel[$urandom_range(0, 4)];
            run_op(op, z, inv, den, r);
            check_res($sformatf("rand%0d", i), r, model(op, z, inv, den));
        end

        // Establish known flags, then flush mid-ITER; a start during ITER must be ignored.
        run_op(0, 3'b110, 1, 0, r);
        check_res("pre-flush", r, model(0, 3'b110, 1, 0));
        prev_nv = 1'b1;
        prev_dz = 1'b1;
        issue(0, 3'b000, 0, 0);
        @(negedge clk);
        start   = 1'b1;
        op_type = 1'b1;
        #1;
        check("start in ITER load_op", int'(load_op), 0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("iter_cnt before flush", int'(iter_cnt), 2);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", int'(busy), 0);
        check("flush iter_cnt", int'(iter_cnt), 0);
        check("flush flag_nv", int'(flag_nv), int'(prev_nv));
        check("flush flag_dz", int'(flag_dz), int'(prev_dz));
        done_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        check("flush no done", done_cnt, 0);

        start = 1'b1;
        flush = 1'b1;
        #1;
        check("start+flush load_op", int'(load_op), 0);
        @(negedge clk);
        check("start+flush busy", int'(busy), 0);
        start = 1'b0;
        flush = 1'b0;

        // A start raised in the DONE cycle must not launch a new operation.
        issue(1, 3'b010, 0, 0);
        @(negedge clk);
        check("special done", int'(done), 1);
        start = 1'b1;
        #1;
        check("start in DONE load_op", int'(load_op), 0);
        @(negedge clk);
        check("start in DONE busy", int'(busy), 0);
        start = 1'b0;

        // Reset in ROUND clears everything immediately; the next start is accepted on release.
        issue(0, 3'b000, 1, 0);
        for (int c = 1; c < 6; c++) @(negedge clk);
        check("reached ROUND", int'(round_en), 1);
        reset_n = 1'b0;
        start   = 1'b1;
        #1;
        check("reset in ROUND outputs", outs_vec(), 0);
        check("reset in ROUND load_op", int'(load_op), 0);
        @(negedge clk);
        check("reset held outputs", outs_vec(), 0);
        reset_n = 1'b1;
        Invalid = 1'b0;
        #1;
        check("post-reset load_op", int'(load_op), 1);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        finish_op(r);
        check_res("post-reset", r, model(0, 3'b000, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
